// File: rtl/reindeer_wb_timer_responder.sv
// Wishbone MM-register responder with an 8-word window hosting a prescaled
// 32-bit down-counting interval timer, sticky expiry flag and level interrupt.
module reindeer_wb_timer_responder #(
  parameter int unsigned          ADDR_BITS = 8,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR = 8'h10,
  parameter int unsigned          READ_WAIT = 1,
  parameter logic [31:0]          ID_VALUE  = 32'h5254_494D
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 WB_RD_CYC_I,
  input  logic                 WB_RD_STB_I,
  input  logic [ADDR_BITS-1:0] WB_RD_ADR_I,
  output logic [31:0]          WB_RD_DAT_O,
  output logic                 WB_RD_ACK_O,
  input  logic                 WB_WR_CYC_I,
  input  logic                 WB_WR_STB_I,
  input  logic                 WB_WR_WE_I,
  input  logic [3:0]           WB_WR_SEL_I,
  input  logic [ADDR_BITS-1:0] WB_WR_ADR_I,
  input  logic [31:0]          WB_WR_DAT_I,
  output logic                 WB_WR_ACK_O,
  output logic                 irq_o
);

  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_ACK} rd_state_e;

  localparam logic [2:0] WAIT_INIT = 3'((READ_WAIT == 0) ? 0 : READ_WAIT - 1);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_LOAD   = 3'd2;
  localparam logic [2:0] OFF_COUNT  = 3'd3;
  localparam logic [2:0] OFF_PRESC  = 3'd4;
  localparam logic [2:0] OFF_ID     = 3'd5;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  // Register state
  logic [2:0]  ctrl_q, ctrl_d;         // [0] enable, [1] auto_reload, [2] irq_en
  logic        expired_q, expired_d;
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic        irq_q;
  logic        wr_ack_q;

  // Read FSM state
  rd_state_e   rd_state_q;
  logic [2:0]  rd_off_q;
  logic [2:0]  rd_wcnt_q;
  logic [31:0] rd_dat_q;
  logic        rd_ack_q;

  // Address decode: window is 8-aligned, so only the upper bits matter
  logic rd_hit, wr_acc;
  logic [2:0] wr_off;

  assign rd_hit = WB_RD_CYC_I & WB_RD_STB_I &
                  (WB_RD_ADR_I[ADDR_BITS-1:3] == BASE_ADDR[ADDR_BITS-1:3]);
  assign wr_acc = WB_WR_CYC_I & WB_WR_STB_I & WB_WR_WE_I &
                  (WB_WR_ADR_I[ADDR_BITS-1:3] == BASE_ADDR[ADDR_BITS-1:3]);
  assign wr_off = WB_WR_ADR_I[2:0];

  logic wr_ctrl, wr_status, wr_load, wr_count, wr_presc;
  assign wr_ctrl   = wr_acc & (wr_off == OFF_CTRL);
  assign wr_status = wr_acc & (wr_off == OFF_STATUS);
  assign wr_load   = wr_acc & (wr_off == OFF_LOAD);
  assign wr_count  = wr_acc & (wr_off == OFF_COUNT);
  assign wr_presc  = wr_acc & (wr_off == OFF_PRESC);

  logic tick, expire, w1c;
  assign tick   = ctrl_q[0] & (pcnt_q == presc_q);
  assign expire = tick & (count_q == 32'd0);
  assign w1c    = wr_status & WB_WR_SEL_I[0] & WB_WR_DAT_I[0];

  // Timer next state; bus writes override the tick for the written register,
  // but an expiry always sets the sticky flag, even against a W1C.
  always_comb begin
    ctrl_d    = ctrl_q;
    expired_d = expired_q;
    load_d    = load_q;
    count_d   = count_q;
    presc_d   = presc_q;
    pcnt_d    = pcnt_q;

    if (wr_presc || !ctrl_q[0] || tick) pcnt_d = 16'd0;
    else                                pcnt_d = pcnt_q + 16'd1;

    if (tick) begin
      if (count_q != 32'd0) count_d = count_q - 32'd1;
      else if (ctrl_q[1])   count_d = load_q;
      else                  ctrl_d[0] = 1'b0;
    end

    if (w1c)    expired_d = 1'b0;
    if (expire) expired_d = 1'b1;

    if (wr_ctrl && WB_WR_SEL_I[0]) ctrl_d = WB_WR_DAT_I[2:0];
    if (wr_load) begin
      load_d  = byte_merge(load_q, WB_WR_DAT_I, WB_WR_SEL_I);
      count_d = load_d;
    end
    if (wr_count) count_d = byte_merge(count_q, WB_WR_DAT_I, WB_WR_SEL_I);
    if (wr_presc) begin
      if (WB_WR_SEL_I[0]) presc_d[7:0]  = WB_WR_DAT_I[7:0];
      if (WB_WR_SEL_I[1]) presc_d[15:8] = WB_WR_DAT_I[15:8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q    <= '0;
      expired_q <= 1'b0;
      load_q    <= '0;
      count_q   <= '0;
      presc_q   <= '0;
      pcnt_q    <= '0;
      irq_q     <= 1'b0;
      wr_ack_q  <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      expired_q <= expired_d;
      load_q    <= load_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      irq_q     <= expired_q & ctrl_q[2];
      wr_ack_q  <= wr_acc;
    end
  end

  // Read mux: in IDLE with READ_WAIT=0 the live address selects directly
  logic [2:0]  rd_sel;
  logic [31:0] rd_mux;

  assign rd_sel = (rd_state_q == RD_IDLE) ? WB_RD_ADR_I[2:0] : rd_off_q;

  always_comb begin
    rd_mux = 32'd0;
    case (rd_sel)
      OFF_CTRL:   rd_mux = {29'd0, ctrl_q};
      OFF_STATUS: rd_mux = {30'd0, ctrl_q[0], expired_q};
      OFF_LOAD:   rd_mux = load_q;
      OFF_COUNT:  rd_mux = count_q;
      OFF_PRESC:  rd_mux = {16'd0, presc_q};
      OFF_ID:     rd_mux = ID_VALUE;
      default:    rd_mux = 32'd0;
    endcase
  end

  // Read FSM; data register only updates on ack so the host can pick it up late
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state_q <= RD_IDLE;
      rd_off_q   <= '0;
      rd_wcnt_q  <= '0;
      rd_dat_q   <= '0;
      rd_ack_q   <= 1'b0;
    end else begin
      rd_ack_q <= 1'b0;
      case (rd_state_q)
        RD_IDLE: begin
          if (rd_hit) begin
            rd_off_q <= WB_RD_ADR_I[2:0];
            if (READ_WAIT == 0) begin
              rd_state_q <= RD_ACK;
              rd_ack_q   <= 1'b1;
              rd_dat_q   <= rd_mux;
            end else begin
              rd_state_q <= RD_WAIT;
              rd_wcnt_q  <= WAIT_INIT;
            end
          end
        end
        RD_WAIT: begin
          if (rd_wcnt_q == 3'd0) begin
            rd_state_q <= RD_ACK;
            rd_ack_q   <= 1'b1;
            rd_dat_q   <= rd_mux;
          end else begin
            rd_wcnt_q <= rd_wcnt_q - 3'd1;
          end
        end
        RD_ACK:  rd_state_q <= RD_IDLE;
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  assign WB_RD_DAT_O = rd_dat_q;
  assign WB_RD_ACK_O = rd_ack_q;
  assign WB_WR_ACK_O = wr_ack_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_reindeer_wb_timer_responder.sv
// Directed bench for the Wishbone timer responder: register access, timer
// modes, collisions, window decode and read FSM corner cases.
module tb_reindeer_wb_timer_responder;

  localparam logic [7:0]  B  = 8'h10;
  localparam logic [31:0] ID = 32'h5254_494D;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        WB_RD_CYC_I = 1'b1, WB_RD_STB_I = 1'b0;
  logic [7:0]  WB_RD_ADR_I = '0;
  logic [31:0] WB_RD_DAT_O;
  logic        WB_RD_ACK_O;
  logic        WB_WR_CYC_I = 1'b1, WB_WR_STB_I = 1'b1, WB_WR_WE_I = 1'b0;
  logic [3:0]  WB_WR_SEL_I = '0;
  logic [7:0]  WB_WR_ADR_I = '0;
  logic [31:0] WB_WR_DAT_I = '0;
  logic        WB_WR_ACK_O;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

  reindeer_wb_timer_responder #(.ADDR_BITS(8), .BASE_ADDR(8'h10), .READ_WAIT(1),
                                .ID_VALUE(32'h5254_494D)) dut (
    .clk(clk), .reset_n(reset_n),
    .WB_RD_CYC_I(WB_RD_CYC_I), .WB_RD_STB_I(WB_RD_STB_I), .WB_RD_ADR_I(WB_RD_ADR_I),
    .WB_RD_DAT_O(WB_RD_DAT_O), .WB_RD_ACK_O(WB_RD_ACK_O),
    .WB_WR_CYC_I(WB_WR_CYC_I), .WB_WR_STB_I(WB_WR_STB_I), .WB_WR_WE_I(WB_WR_WE_I),
    .WB_WR_SEL_I(WB_WR_SEL_I), .WB_WR_ADR_I(WB_WR_ADR_I), .WB_WR_DAT_I(WB_WR_DAT_I),
    .WB_WR_ACK_O(WB_WR_ACK_O), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  // Bus drivers; called at posedge+1, return at posedge+1
  task automatic wb_write(input logic [7:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output logic ack);
    WB_WR_WE_I = 1'b1; WB_WR_ADR_I = adr; WB_WR_DAT_I = dat; WB_WR_SEL_I = sel;
    @(posedge clk); #1;
    WB_WR_WE_I = 1'b0;
    ack = WB_WR_ACK_O;
  endtask

  // lat = -1 when no ack arrives within the budget
  task automatic wb_read(input logic [7:0] adr, output logic [31:0] dat, output int lat);
    WB_RD_STB_I = 1'b1; WB_RD_ADR_I = adr;
    @(posedge clk); #1;
    WB_RD_STB_I = 1'b0;
    lat = 1;
    while (!WB_RD_ACK_O && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!WB_RD_ACK_O) begin
      lat = -1;
      dat = '0;
    end else begin
      dat = WB_RD_DAT_O;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int lat;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (WB_RD_DAT_O !== 32'd0) begin errors++; $display("FAIL reset_rd_dat: got %h want 0", WB_RD_DAT_O); end
    checks++; if (WB_RD_ACK_O !== 1'b0) begin errors++; $display("FAIL reset_rd_ack: got %b want 0", WB_RD_ACK_O); end
    checks++; if (WB_WR_ACK_O !== 1'b0) begin errors++; $display("FAIL reset_wr_ack: got %b want 0", WB_WR_ACK_O); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq_o); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      wb_read(8'(B + i), d, lat);
      checks++; if (lat !== 2 || d !== 32'd0) begin errors++; $display("FAIL reset_reg%0d: got %h lat %0d want 0 lat 2", i, d, lat); end
    end
  endtask

  task automatic test_id_read();
    logic [31:0] d;
    logic ack;
    int lat;
    wb_read(B + 8'd5, d, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL id_latency: got %0d want 2", lat); end
    checks++; if (d !== ID) begin errors++; $display("FAIL id_data: got %h want %h", d, ID); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (WB_RD_DAT_O !== ID || WB_RD_ACK_O !== 1'b0) begin errors++; $display("FAIL id_hold: got %h ack %b want %h ack 0", WB_RD_DAT_O, WB_RD_ACK_O, ID); end
    wb_write(B + 8'd6, 32'hFFFF_FFFF, 4'hF, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL off6_wr_ack: got %b want 1", ack); end
    wb_read(B + 8'd6, d, lat);
    checks++; if (lat !== 2 || d !== 32'd0) begin errors++; $display("FAIL off6_read: got %h lat %0d want 0 lat 2", d, lat); end
    wb_read(B + 8'd7, d, lat);
    checks++; if (lat !== 2 || d !== 32'd0) begin errors++; $display("FAIL off7_read: got %h lat %0d want 0 lat 2", d, lat); end
  endtask

  task automatic test_byte_write();
    logic [31:0] d;
    logic ack;
    int lat;
    wb_write(B + 8'd2, 32'h1234_5678, 4'b0011, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL load_wr_ack: got %b want 1", ack); end
    @(posedge clk); #1;
    checks++; if (WB_WR_ACK_O !== 1'b0) begin errors++; $display("FAIL load_wr_ack_pulse: got %b want 0", WB_WR_ACK_O); end
    wb_read(B + 8'd2, d, lat);
    checks++; if (d !== 32'h0000_5678) begin errors++; $display("FAIL load_bytes: got %h want 00005678", d); end
    wb_read(B + 8'd3, d, lat);
    checks++; if (d !== 32'h0000_5678) begin errors++; $display("FAIL count_copy: got %h want 00005678", d); end
  endtask

  task automatic test_autoreload();
    logic [31:0] d;
    logic ack;
    int lat, n;
    wb_write(B + 8'd4, 32'd0, 4'hF, ack);
    wb_write(B + 8'd2, 32'd5, 4'hF, ack);
    wb_write(B + 8'd0, 32'h7, 4'hF, ack);
    n = 0;
    while (!irq_o && n < 30) begin @(posedge clk); #1; n++; end
    checks++; if (n !== 7) begin errors++; $display("FAIL auto_irq_delay: got %0d want 7", n); end
    // Tick at A+7 (5->4) and A+8 (4->3) alongside the disabling write
    wb_write(B + 8'd0, 32'h0, 4'hF, ack);
    wb_read(B + 8'd3, d, lat);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL auto_count: got %h want 3", d); end
    wb_read(B + 8'd1, d, lat);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL auto_status: got %h want 1", d); end
    wb_write(B + 8'd1, 32'h1, 4'h1, ack);
    wb_read(B + 8'd1, d, lat);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL auto_w1c: got %h want 0", d); end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    logic ack;
    int lat, n;
    wb_write(B + 8'd2, 32'd5, 4'hF, ack);
    wb_write(B + 8'd0, 32'h5, 4'hF, ack);
    n = 0;
    while (!irq_o && n < 30) begin @(posedge clk); #1; n++; end
    checks++; if (n !== 7) begin errors++; $display("FAIL oneshot_irq_delay: got %0d want 7", n); end
    wb_read(B + 8'd3, d, lat);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL oneshot_count: got %h want 0", d); end
    wb_read(B + 8'd0, d, lat);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL oneshot_ctrl: got %h want 4", d); end
    wb_read(B + 8'd1, d, lat);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL oneshot_status: got %h want 1", d); end
    wb_write(B + 8'd1, 32'h1, 4'h1, ack);
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL oneshot_irq_hold: got %b want 1", irq_o); end
    @(posedge clk); #1;
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL oneshot_irq_drop: got %b want 0", irq_o); end
    wb_read(B + 8'd1, d, lat);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL oneshot_w1c: got %h want 0", d); end
  endtask

  task automatic test_prescale_collision();
    logic [31:0] d;
    logic ack;
    int lat;
    wb_write(B + 8'd4, 32'h3, 4'hF, ack);
    wb_write(B + 8'd2, 32'h1, 4'hF, ack);
    wb_write(B + 8'd0, 32'h3, 4'hF, ack);
    // Ticks land at A+4 (1->0) and A+8 (expiry); the W1C is accepted at A+8
    repeat (7) @(posedge clk);
    #1;
    wb_write(B + 8'd1, 32'h1, 4'h1, ack);
    wb_read(B + 8'd1, d, lat);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL presc_collision: got %h want 3", d); end
    wb_read(B + 8'd4, d, lat);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL presc_readback: got %h want 3", d); end
    wb_write(B + 8'd0, 32'h0, 4'hF, ack);
    wb_write(B + 8'd1, 32'h1, 4'h1, ack);
    wb_read(B + 8'd1, d, lat);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL presc_w1c: got %h want 0", d); end
  endtask

  task automatic test_window();
    logic [31:0] d;
    logic ack;
    int lat;
    wb_write(B + 8'd8, 32'hFFFF_FFFF, 4'hF, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL win_wr_hi_ack: got %b want 0", ack); end
    wb_write(B - 8'd1, 32'hFFFF_FFFF, 4'hF, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL win_wr_lo_ack: got %b want 0", ack); end
    wb_write(B + 8'd10, 32'hDEAD_BEEF, 4'hF, ack);
    wb_read(B + 8'd8, d, lat);
    checks++; if (lat !== -1) begin errors++; $display("FAIL win_rd_hi: got lat %0d want no ack", lat); end
    wb_read(B - 8'd1, d, lat);
    checks++; if (lat !== -1) begin errors++; $display("FAIL win_rd_lo: got lat %0d want no ack", lat); end
    wb_read(B + 8'd0, d, lat);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL win_ctrl: got %h want 0", d); end
    wb_read(B + 8'd2, d, lat);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL win_load: got %h want 1", d); end
  endtask

  task automatic test_back_to_back();
    int acks;
    logic [31:0] d;
    WB_RD_STB_I = 1'b1; WB_RD_ADR_I = B + 8'd5;
    @(posedge clk); #1;
    WB_RD_ADR_I = B + 8'd2;
    @(posedge clk); #1;
    WB_RD_STB_I = 1'b0;
    acks = int'(WB_RD_ACK_O);
    d = WB_RD_DAT_O;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      acks += int'(WB_RD_ACK_O);
    end
    checks++; if (acks !== 1) begin errors++; $display("FAIL b2b_ack_count: got %0d want 1", acks); end
    checks++; if (d !== ID) begin errors++; $display("FAIL b2b_data: got %h want %h", d, ID); end
  endtask

  task automatic test_reset_mid();
    int acks;
    logic [31:0] d;
    int lat;
    WB_RD_STB_I = 1'b1; WB_RD_ADR_I = B + 8'd5;
    @(posedge clk); #1;
    WB_RD_STB_I = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++; if (WB_RD_DAT_O !== 32'd0 || WB_RD_ACK_O !== 1'b0) begin errors++; $display("FAIL midrst_out: got %h ack %b want 0", WB_RD_DAT_O, WB_RD_ACK_O); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      acks += int'(WB_RD_ACK_O);
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL midrst_ack: got %0d want 0", acks); end
    wb_read(B + 8'd2, d, lat);
    checks++; if (lat !== 2 || d !== 32'd0) begin errors++; $display("FAIL midrst_load: got %h lat %0d want 0 lat 2", d, lat); end
  endtask

  initial begin
    test_reset();
    test_id_read();
    test_byte_write();
    test_autoreload();
    test_oneshot();
    test_prescale_collision();
    test_window();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
